instruction_fetch: RTL

Instruction-side companion to the program counter in the Hack CPU. It consumes fetch addresses from the PC stage, drives the synchronous instruction ROM (block RAM, 1-cycle read latency) and hides that latency. It buffers returned instructions in a small FIFO and presents them to decode over a valid/ready handshake. A `flush` input discards everything in flight when a jump is taken, so no stale instruction reaches decode.

---
 rtl/hack_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/instruction_fetch.sv | 110 +++++++++++
 3 files changed

// File: rtl/hack_pkg.sv
// Shared Hack CPU types: instruction word, 16-bit address and the fetch FIFO entry.
package hack_pkg;
  localparam int INST_W     = 16;
  localparam int ADDR_W     = 16;
  localparam int ROM_AW_DEF = 15;

  typedef logic [INST_W-1:0] inst_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    inst_t data;
    addr_t addr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous circular FIFO of fetch entries with a synchronous clear.
// Latency: a push is visible at the head the cycle after the push edge.
// Backpressure: none internally; the caller's credit scheme must keep pushes off a full FIFO.
module fetch_fifo
  import hack_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int WIDTH = $bits(fetch_entry_t)
) (
  input  logic                       clk,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        occupancy <= occupancy + 1'b1;
      end else if (pop && !push) begin
        occupancy <= occupancy - 1'b1;
      end
    end
  end

  // The credit rule upstream must make this impossible.
  push_not_full: assert property (@(posedge clk) disable iff (clear)
    !(push && occupancy == OW'(DEPTH)));
endmodule

// File: rtl/instruction_fetch.sv
// Fetch unit: hides the 1-cycle ROM read and buffers instructions for decode (IFETCH_STATS_EN adds counters).
// Latency: 2 cycles from accepted request to inst_valid; 1 instruction/cycle sustained when DEPTH >= 3.
// Backpressure: credit-based req_ready (occupancy + in-flight < DEPTH); flush discards everything in flight.
module instruction_fetch
  import hack_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int ROM_AW = ROM_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  addr_t             req_addr,
  input  logic              flush,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  inst_t             rom_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output inst_t             inst_data,
  output addr_t             inst_addr
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [15:0]       stat_flushed
`endif
);
  localparam int OW = $clog2(DEPTH+1);

  logic         inflight;
  addr_t        inflight_addr;
  logic         inflight_drop;
  logic [OW-1:0] occupancy;
  logic [OW:0]  credit_used;
  logic         accept;
  logic         push;
  logic         pop;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  assign credit_used = {1'b0, occupancy} + {{OW{1'b0}}, inflight};
  assign req_ready   = !reset && !flush && (credit_used < (OW+1)'(DEPTH));
  assign accept      = req_valid && req_ready;
  assign rom_en      = accept;
  assign rom_addr    = req_addr[ROM_AW-1:0];

  // A read landing in the flush cycle is discarded along with the FIFO.
  assign push       = inflight && !inflight_drop && !flush;
  assign push_entry = '{data: rom_data, addr: inflight_addr};

  assign inst_valid = (occupancy != '0);
  assign pop        = inst_valid && inst_ready;
  assign inst_data  = inst_valid ? head_entry.data : '0;
  assign inst_addr  = inst_valid ? head_entry.addr : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight      <= 1'b0;
      inflight_addr <= '0;
      inflight_drop <= 1'b0;
    end else begin
      inflight <= accept;
      if (accept) begin
        inflight_addr <= req_addr;
        inflight_drop <= 1'b0;
      end else if (flush) begin
        inflight_drop <= 1'b1;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .clear     (reset || flush),
    .push      (push),
    .push_dat  (push_entry),
    .pop       (pop),
    .head_dat  (head_entry),
    .occupancy (occupancy)
  );

`ifdef IFETCH_STATS_EN
  logic [15:0] discard_cnt;
  logic [16:0] flushed_sum;

  // Entries popped in the flush cycle count as fetched, not discarded.
  always_comb begin
    discard_cnt = 16'(occupancy) - 16'(pop) + 16'(inflight && !inflight_drop);
    flushed_sum = {1'b0, stat_flushed} + {1'b0, discard_cnt};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fetched <= '0;
      stat_flushed <= '0;
    end else begin
      if (pop && stat_fetched != '1) begin
        stat_fetched <= stat_fetched + 1'b1;
      end
      if (flush) begin
        stat_flushed <= flushed_sum[16] ? '1 : flushed_sum[15:0];
      end
    end
  end
`endif
endmodule
